// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle RV32I core control path.
package cpu_pkg;

    localparam logic [6:0] RTYPE   = 7'b0110011;
    localparam logic [6:0] ITYPE   = 7'b0010011;
    localparam logic [6:0] LTYPE   = 7'b0000011;
    localparam logic [6:0] STYPE   = 7'b0100011;
    localparam logic [6:0] BTYPE   = 7'b1100011;
    localparam logic [6:0] JTYPE   = 7'b1101111;
    localparam logic [6:0] J_ITYPE = 7'b1100111;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;

    typedef enum logic [3:0] {
        START    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        EXEC_U   = 4'd5,
        ALU_WB   = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JAL      = 4'd12,
        EXEC_JR  = 4'd13,
        JALR     = 4'd14,
        HALT     = 4'd15
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10,
        SRC_A_ZERO  = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_PC     = 2'b10
    } result_src_t;

    // States that issue a memory request and may wait on mem_ready.
    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/alu_cfg_sel.sv
// Chooses the shared ALU's opcode/func3/func7 from the control state and IR fields.
module alu_cfg_sel
    import cpu_pkg::*;
(
    input  ctrl_state_t state,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        func7,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_func3,
    output logic        alu_func7
);

    // Forced add for PC/target/U-type arithmetic, IR passthrough for real ALU ops.
    always_comb begin
        alu_opcode = 7'd0;
        alu_func3  = 3'd0;
        alu_func7  = 1'b0;
        case (state)
            FETCH, DECODE, EXEC_U: alu_opcode = ITYPE;
            EXEC_R, EXEC_I: begin
                alu_opcode = opcode;
                alu_func3  = func3;
                alu_func7  = func7;
            end
            MEM_ADDR: alu_opcode = LTYPE;
            EXEC_JR:  alu_opcode = J_ITYPE;
            default:  alu_opcode = 7'd0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction
// and drives every datapath enable, mux select and the shared ALU configuration.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [6:0] alu_opcode,
    output logic [2:0] alu_func3,
    output logic       alu_func7,
    output logic       instr_done,
    output logic       halted,
    output logic       err
);

    // The timeout fires on the last permitted waiting cycle so HALT is entered
    // exactly MEM_WAIT_MAX cycles after the memory state was entered.
    localparam logic [7:0] WAIT_LAST = (MEM_WAIT_MAX == 0) ? 8'd0 : 8'(MEM_WAIT_MAX - 1);

    ctrl_state_t state_r;
    ctrl_state_t state_next_s;
    logic [7:0]  wait_cnt_r;
    logic        err_r;
    logic        err_set_s;
    logic        timeout_s;
    alu_src_a_t  src_a_s;
    alu_src_b_t  src_b_s;
    result_src_t res_s;

    // Memory-wait timeout; mem_ready on the same cycle takes priority in the FSM.
    always_comb begin
        timeout_s = 1'b0;
        if ((MEM_WAIT_MAX != 0) && is_mem_state(state_r) && !mem_ready) begin
            timeout_s = (wait_cnt_r == WAIT_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        err_set_s    = 1'b0;
        case (state_r)
            START: state_next_s = FETCH;
            FETCH, MEM_RD, MEM_WR: begin
                if (mem_ready) begin
                    if (state_r == FETCH) begin
                        state_next_s = DECODE;
                    end else if (state_r == MEM_RD) begin
                        state_next_s = MEM_WB;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else if (timeout_s) begin
                    state_next_s = HALT;
                    err_set_s    = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            DECODE: begin
                case (opcode)
                    RTYPE:        state_next_s = EXEC_R;
                    ITYPE:        state_next_s = EXEC_I;
                    LTYPE, STYPE: state_next_s = MEM_ADDR;
                    BTYPE:        state_next_s = BRANCH;
                    JTYPE:        state_next_s = JAL;
                    J_ITYPE:      state_next_s = EXEC_JR;
                    LUI, AUIPC:   state_next_s = EXEC_U;
                    default: begin
                        state_next_s = HALT;
                        err_set_s    = 1'b1;
                    end
                endcase
            end
            EXEC_R, EXEC_I, EXEC_U: state_next_s = ALU_WB;
            MEM_ADDR: begin
                if (opcode == LTYPE) begin
                    state_next_s = MEM_RD;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            EXEC_JR: state_next_s = JALR;
            ALU_WB, MEM_WB, BRANCH, JAL, JALR: state_next_s = FETCH;
            HALT: state_next_s = HALT;
            default: begin
                state_next_s = HALT;
                err_set_s    = 1'b1;
            end
        endcase
    end

    // Moore output decode (strobes qualified by mem_ready/branch_taken where needed).
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        src_a_s    = SRC_A_PC;
        src_b_s    = SRC_B_RS2;
        res_s      = RES_ALUOUT;
        case (state_r)
            FETCH: begin
                mem_req  = 1'b1;
                src_b_s  = SRC_B_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                src_a_s = SRC_A_OLDPC;
                src_b_s = SRC_B_IMM;
            end
            EXEC_R: src_a_s = SRC_A_RS1;
            EXEC_I, MEM_ADDR, EXEC_JR: begin
                src_a_s = SRC_A_RS1;
                src_b_s = SRC_B_IMM;
            end
            EXEC_U: begin
                if (opcode == LUI) begin
                    src_a_s = SRC_A_ZERO;
                end else begin
                    src_a_s = SRC_A_OLDPC;
                end
                src_b_s = SRC_B_IMM;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                res_s      = RES_MEM;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            BRANCH: begin
                pc_write   = branch_taken;
                pc_src     = 1'b1;
                instr_done = 1'b1;
            end
            JAL, JALR: begin
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                res_s      = RES_PC;
                instr_done = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign alu_src_a  = src_a_s;
    assign alu_src_b  = src_b_s;
    assign result_src = res_s;
    assign err        = err_r;

    alu_cfg_sel u_alu_cfg_sel (
        .state      (state_r),
        .opcode     (opcode),
        .func3      (func3),
        .func7      (func7),
        .alu_opcode (alu_opcode),
        .alu_func3  (alu_func3),
        .alu_func7  (alu_func7)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= START;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory wait counter: counts consecutive waiting cycles, cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
        end else if (is_mem_state(state_r) && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of per-instruction cycle counts,
// a phase-level instruction model driven with random waits/opcodes, and timeout/reset corners.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic [6:0] aop;
        logic [2:0] af3;
        logic       af7;
        logic       done;
        logic       halted;
        logic       err;
    } out_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       bt;
        int         cycles;
        int         regw;
        int         pcw;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst1, mem_ready0, mem_ready1, branch_taken, func7;
    logic [6:0] opcode;
    logic [2:0] func3;
    out_t       act0, act1;

    int checks = 0;
    int passes = 0;

    multicycle_ctrl dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .mem_ready(mem_ready0), .branch_taken(branch_taken),
        .mem_req(act0.mem_req), .mem_we(act0.mem_we), .adr_src(act0.adr_src),
        .ir_write(act0.ir_write), .pc_write(act0.pc_write), .reg_write(act0.reg_write),
        .pc_src(act0.pc_src), .alu_src_a(act0.a), .alu_src_b(act0.b),
        .result_src(act0.res), .alu_opcode(act0.aop), .alu_func3(act0.af3),
        .alu_func7(act0.af7), .instr_done(act0.done), .halted(act0.halted), .err(act0.err)
    );

    multicycle_ctrl #(.MEM_WAIT_MAX(5)) dut1 (
        .clk(clk), .rst(rst1), .opcode(opcode), .func3(func3), .func7(func7),
        .mem_ready(mem_ready1), .branch_taken(branch_taken),
        .mem_req(act1.mem_req), .mem_we(act1.mem_we), .adr_src(act1.adr_src),
        .ir_write(act1.ir_write), .pc_write(act1.pc_write), .reg_write(act1.reg_write),
        .pc_src(act1.pc_src), .alu_src_a(act1.a), .alu_src_b(act1.b),
        .result_src(act1.res), .alu_opcode(act1.aop), .alu_func3(act1.af3),
        .alu_func7(act1.af7), .instr_done(act1.done), .halted(act1.halted), .err(act1.err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t o_add(input logic [1:0] a, input logic [1:0] b);
        out_t o;
        o = '0;
        o.a = a;
        o.b = b;
        o.aop = 7'b0010011;
        return o;
    endfunction

    function automatic out_t o_link();
        out_t o;
        o = '0;
        o.pc_write = 1'b1;
        o.pc_src = 1'b1;
        o.reg_write = 1'b1;
        o.res = 2'b10;
        o.done = 1'b1;
        return o;
    endfunction

    function automatic out_t o_rs1(input logic [1:0] b, input logic [6:0] aop);
        out_t o;
        o = '0;
        o.a = 2'b10;
        o.b = b;
        o.aop = aop;
        return o;
    endfunction

    // IR changes in these states must not matter.
    task automatic scramble();
        opcode = 7'($urandom);
        func3 = 3'($urandom);
        func7 = rb();
    endtask

    // One clock cycle: apply inputs, compare outputs mid-cycle, advance to posedge+1.
    task automatic cyc(input int sel, input logic rdy, input logic bt, input out_t exp, input string name);
        out_t a;
        if (sel == 0) mem_ready0 = rdy; else mem_ready1 = rdy;
        branch_taken = bt;
        @(negedge clk);
        a = (sel == 0) ? act0 : act1;
        check(name, {5'd0, a}, {5'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int sel);
        out_t a;
        if (sel == 0) rst = 1'b1; else rst1 = 1'b1;
        #1;
        a = (sel == 0) ? act0 : act1;
        check("reset_async_zero", {5'd0, a}, 32'd0);
        @(posedge clk); #1;
        if (sel == 0) rst = 1'b0; else rst1 = 1'b0;
        #1;
        a = (sel == 0) ? act0 : act1;
        check("start_zero", {5'd0, a}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Phase-level model of one instruction starting at FETCH entry.
    task automatic run_instr(input int sel, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic bt, input int wf, input int wm, input int hc);
        out_t o;
        logic st;
        scramble();
        o = o_add(2'b00, 2'b10);
        o.mem_req = 1'b1;
        for (int i = 0; i < wf; i++) cyc(sel, 1'b0, rb(), o, "fetch_wait");
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
        cyc(sel, 1'b1, rb(), o, "fetch_ready");
        opcode = op; func3 = f3; func7 = f7;
        cyc(sel, rb(), rb(), o_add(2'b01, 2'b01), "decode");
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                if (op == 7'b0110111) o = o_add(2'b11, 2'b01);
                else if (op == 7'b0010111) o = o_add(2'b01, 2'b01);
                else begin
                    o = o_rs1((op == 7'b0010011) ? 2'b01 : 2'b00, op);
                    o.af3 = f3;
                    o.af7 = f7;
                end
                cyc(sel, rb(), rb(), o, "exec");
                scramble();
                o = '0; o.reg_write = 1'b1; o.done = 1'b1;
                cyc(sel, rb(), rb(), o, "alu_wb");
            end
            7'b0000011, 7'b0100011: begin
                st = (op == 7'b0100011);
                cyc(sel, rb(), rb(), o_rs1(2'b01, 7'b0000011), "mem_addr");
                o = '0; o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_we = st;
                for (int i = 0; i < wm; i++) cyc(sel, 1'b0, rb(), o, "mem_wait");
                o.done = st;
                cyc(sel, 1'b1, rb(), o, "mem_ready");
                if (!st) begin
                    scramble();
                    o = '0; o.reg_write = 1'b1; o.res = 2'b01; o.done = 1'b1;
                    cyc(sel, rb(), rb(), o, "mem_wb");
                end
            end
            7'b1100011: begin
                scramble();
                o = '0; o.pc_write = bt; o.pc_src = 1'b1; o.done = 1'b1;
                cyc(sel, rb(), bt, o, "branch");
            end
            7'b1101111: begin
                scramble();
                cyc(sel, rb(), rb(), o_link(), "jal");
            end
            7'b1100111: begin
                cyc(sel, rb(), rb(), o_rs1(2'b01, 7'b1100111), "exec_jr");
                scramble();
                cyc(sel, rb(), rb(), o_link(), "jalr");
            end
            default: begin
                o = '0; o.halted = 1'b1; o.err = 1'b1;
                for (int i = 0; i < hc; i++) begin
                    scramble();
                    cyc(sel, rb(), rb(), o, "halt");
                end
            end
        endcase
    endtask

    function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic bt, input int c, input int r, input int p);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.bt = bt;
        v.cycles = c; v.regw = r; v.pcw = p;
        return v;
    endfunction

    vec_t vq[$];
    logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        out_t o;
        int cycles, regw, pcw;
        logic seen;
        rst = 1'b1; rst1 = 1'b1; mem_ready0 = 1'b0; mem_ready1 = 1'b0;
        branch_taken = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 1'b0;
        @(posedge clk); #1;
        do_reset(0);

        // Zero-wait cycle counts and strobe totals per instruction class.
        vq.push_back(mk("add",   7'b0110011, 3'd0, 1'b0, 1'b0, 4, 1, 1));
        vq.push_back(mk("sub",   7'b0110011, 3'd0, 1'b1, 1'b0, 4, 1, 1));
        vq.push_back(mk("addi",  7'b0010011, 3'd0, 1'b0, 1'b0, 4, 1, 1));
        vq.push_back(mk("lui",   7'b0110111, 3'd0, 1'b0, 1'b0, 4, 1, 1));
        vq.push_back(mk("auipc", 7'b0010111, 3'd0, 1'b0, 1'b0, 4, 1, 1));
        vq.push_back(mk("lw",    7'b0000011, 3'd2, 1'b0, 1'b0, 5, 1, 1));
        vq.push_back(mk("sw",    7'b0100011, 3'd2, 1'b0, 1'b0, 4, 0, 1));
        vq.push_back(mk("beq_nt",7'b1100011, 3'd0, 1'b0, 1'b0, 3, 0, 1));
        vq.push_back(mk("beq_t", 7'b1100011, 3'd0, 1'b0, 1'b1, 3, 0, 2));
        vq.push_back(mk("jal",   7'b1101111, 3'd0, 1'b0, 1'b0, 3, 1, 2));
        vq.push_back(mk("jalr",  7'b1100111, 3'd0, 1'b0, 1'b0, 4, 1, 2));
        foreach (vq[k]) begin
            opcode = vq[k].op; func3 = vq[k].f3; func7 = vq[k].f7;
            branch_taken = vq[k].bt; mem_ready0 = 1'b1;
            cycles = 0; regw = 0; pcw = 0; seen = 1'b0;
            while (!seen && cycles < 20) begin
                @(negedge clk);
                cycles++;
                regw += int'(act0.reg_write);
                pcw += int'(act0.pc_write);
                seen = act0.done;
                @(posedge clk); #1;
            end
            check({vq[k].name, "_cycles"}, 32'(cycles), 32'(vq[k].cycles));
            check({vq[k].name, "_reg_write"}, 32'(regw), 32'(vq[k].regw));
            check({vq[k].name, "_pc_write"}, 32'(pcw), 32'(vq[k].pcw));
        end

        // Directed model runs.
        run_instr(0, 7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        run_instr(0, 7'b0100011, 3'd2, 1'b0, 1'b0, 0, 3, 0);
        run_instr(0, 7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        run_instr(0, 7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, 0);
        run_instr(0, 7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        run_instr(0, 7'b0000011, 3'd2, 1'b0, 1'b0, 2, 1, 0);

        // Random instruction stream with random waits.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 9)];
            run_instr(0, op, 3'($urandom), rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3), 3);
            if (op == 7'b1111111) do_reset(0);
        end

        // Illegal opcode: sticky halt, then reset clears it.
        run_instr(0, 7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0, 100);
        do_reset(0);

        // MEM_WAIT_MAX=5: FETCH timeout lands in HALT five cycles after entry.
        do_reset(1);
        o = o_add(2'b00, 2'b10);
        o.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1, 1'b0, rb(), o, "to_fetch_wait");
        o = '0; o.halted = 1'b1; o.err = 1'b1;
        cyc(1, 1'b0, rb(), o, "to_halt");
        cyc(1, 1'b1, rb(), o, "to_halt_sticky");

        // Reset in the middle of a memory wait abandons it immediately.
        do_reset(1);
        o = o_add(2'b00, 2'b10);
        o.mem_req = 1'b1;
        for (int i = 0; i < 2; i++) cyc(1, 1'b0, rb(), o, "mid_wait");
        do_reset(1);

        // Four waits then ready (ready wins at the limit), counter restarts for MEM_RD.
        run_instr(1, 7'b0000011, 3'd2, 1'b0, 1'b0, 4, 4, 0);
        rst1 = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
